// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared encodings for the TMP101 I2C read controller
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    RD_MSB,
    ACK_MSB,
    RD_LSB,
    NACK_LSB,
    STOP,
    DONE
  } stateT;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } phaseT;

  // TMP101 with ADD0 tied to ground
  localparam logic [6:0] TMP101_ADDR = 7'b1001000;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Address byte as it goes on the wire: 7-bit address followed by R/W
  function automatic logic [7:0] addrByte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - CLK_DIV divider producing quarter-phase ticks and index
module i2c_quarter_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic  Clock,
  input  logic  Reset,
  input  logic  Enable,
  output logic  Tick,
  output phaseT Phase
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] divCnt;
  logic [1:0]       phaseCnt;

  // Tick marks the last clock of the current quarter-phase
  assign Tick  = Enable && (divCnt == DIV_LAST);
  assign Phase = phaseT'(phaseCnt);

  // Divider and phase counter; held at zero whenever the controller is idle
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      divCnt   <= '0;
      phaseCnt <= 2'd0;
    end else if (!Enable) begin
      divCnt   <= '0;
      phaseCnt <= 2'd0;
    end else if (Tick) begin
      divCnt   <= '0;
      phaseCnt <= phaseCnt + 2'd1;
    end else begin
      divCnt   <= divCnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_tmp101_read_ctrl.sv
// rtl/i2c_tmp101_read_ctrl.sv - single two-byte TMP101 temperature read sequencer
module i2c_tmp101_read_ctrl
  import i2c_pkg::*;
#(
  parameter int         CLK_DIV    = 125,
  parameter logic [6:0] SLAVE_ADDR = TMP101_ADDR
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        ShiftDataIn,
  output logic        SCL,
  output logic        ReadOrWrite,
  output logic        Select,
  output logic        StartStopAck,
  output logic        ShiftDataOut,
  output logic [15:0] TempData,
  output logic        DataValid,
  output logic        Busy,
  output logic        AckError
);

  localparam logic [7:0] ADDR_BYTE = addrByte(SLAVE_ADDR, RW_READ);

  stateT      state, nextState;
  phaseT      phase;
  logic       tick;
  logic       slotEnd;
  logic       sampleNow;
  logic       byteEnd;
  logic       sclHigh;
  logic [2:0] bitCnt;
  logic [7:0] msbShadow;
  logic [7:0] lsbShadow;

  i2c_quarter_tick #(
    .CLK_DIV(CLK_DIV)
  ) uTick (
    .Clock (Clock),
    .Reset (Reset),
    .Enable(state != IDLE),
    .Tick  (tick),
    .Phase (phase)
  );

  assign slotEnd   = tick && (phase == Q3);
  assign sampleNow = tick && (phase == Q2);
  assign byteEnd   = slotEnd && (bitCnt == 3'd7);
  assign sclHigh   = (phase == Q2) || (phase == Q3);

  // DONE is the hand-off cycle: the result is already in TempData and Busy is down
  assign DataValid = (state == DONE) && !AckError;
  assign Busy      = (state != IDLE) && (state != DONE);

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state sequencing and SCL/SDA mux control per slot
  always_comb begin
    nextState    = state;
    SCL          = 1'b1;
    ReadOrWrite  = 1'b0;
    Select       = 1'b0;
    StartStopAck = 1'b1;
    ShiftDataOut = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) nextState = START;
      end
      START: begin
        StartStopAck = !sclHigh;
        if (slotEnd) nextState = ADDR;
      end
      ADDR: begin
        SCL          = sclHigh;
        Select       = 1'b1;
        ShiftDataOut = ADDR_BYTE[3'd7 - bitCnt];
        if (byteEnd) nextState = ADDR_ACK;
      end
      ADDR_ACK: begin
        SCL         = sclHigh;
        ReadOrWrite = 1'b1;
        if (slotEnd) nextState = AckError ? STOP : RD_MSB;
      end
      RD_MSB: begin
        SCL         = sclHigh;
        ReadOrWrite = 1'b1;
        if (byteEnd) nextState = ACK_MSB;
      end
      ACK_MSB: begin
        SCL          = sclHigh;
        StartStopAck = 1'b0;
        if (slotEnd) nextState = RD_LSB;
      end
      RD_LSB: begin
        SCL         = sclHigh;
        ReadOrWrite = 1'b1;
        if (byteEnd) nextState = NACK_LSB;
      end
      NACK_LSB: begin
        SCL = sclHigh;
        if (slotEnd) nextState = STOP;
      end
      STOP: begin
        // SCL rises a quarter before SDA so SDA goes high while SCL is high
        SCL          = (phase != Q0);
        StartStopAck = sclHigh;
        if (slotEnd) nextState = DONE;
      end
      DONE: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Bit counting, sampling of SDA into the shadow bytes, ACK status and result load
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bitCnt    <= 3'd0;
      msbShadow <= 8'h00;
      lsbShadow <= 8'h00;
      AckError  <= 1'b0;
      TempData  <= 16'h0000;
    end else begin
      if (state == IDLE && Start) begin
        AckError <= 1'b0;
        bitCnt   <= 3'd0;
      end
      if (sampleNow) begin
        if (state == ADDR_ACK) AckError  <= ShiftDataIn;
        if (state == RD_MSB)   msbShadow <= {msbShadow[6:0], ShiftDataIn};
        if (state == RD_LSB)   lsbShadow <= {lsbShadow[6:0], ShiftDataIn};
      end
      if (slotEnd && (state == ADDR || state == RD_MSB || state == RD_LSB)) begin
        bitCnt <= bitCnt + 3'd1;
      end
      // Load on the way into DONE so TempData is current while DataValid is high
      if (state == STOP && slotEnd && !AckError) begin
        TempData <= {msbShadow, lsbShadow};
      end
    end
  end

endmodule

// File: tb/tb_i2c_tmp101_read_ctrl.sv
// tb/tb_i2c_tmp101_read_ctrl.sv - scoreboard bench with a behavioural TMP101 slave
module tb_i2c_tmp101_read_ctrl;

  localparam int         CLK_DIV   = 2;
  localparam int         SLOT_CLKS = 4 * CLK_DIV;
  localparam int         CLK_PER   = 10;
  localparam logic [7:0] EXP_ADDR  = 8'h91;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  wire         ShiftDataIn;
  logic        SCL, ReadOrWrite, Select, StartStopAck, ShiftDataOut;
  logic [15:0] TempData;
  logic        DataValid, Busy, AckError;

  wire  sdaLine;
  logic slaveSda = 1'b1;

  assign sdaLine     = ReadOrWrite ? slaveSda : (Select ? ShiftDataOut : StartStopAck);
  assign ShiftDataIn = sdaLine;

  i2c_tmp101_read_ctrl #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .ShiftDataIn (ShiftDataIn),
    .SCL         (SCL),
    .ReadOrWrite (ReadOrWrite),
    .Select      (Select),
    .StartStopAck(StartStopAck),
    .ShiftDataOut(ShiftDataOut),
    .TempData    (TempData),
    .DataValid   (DataValid),
    .Busy        (Busy),
    .AckError    (AckError)
  );

  always #(CLK_PER / 2) Clock = ~Clock;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- behavioural TMP101 slave ----------------
  int         bitIdx = 99;
  bit         slvActive = 1'b0;
  bit         nacked = 1'b0;
  bit         forceNack = 1'b0;
  logic [7:0] slvMsb = 8'h00, slvLsb = 8'h00, rxAddr = 8'h00;
  logic       mAck, mNack;
  int         startSeen = 0, stopSeen = 0, sclFalls = 0, periodErr = 0;
  time        lastFall = 0;

  // START: SDA falls while SCL stays high
  always @(negedge sdaLine) begin
    #1;
    if (Reset && SCL && !sdaLine) begin
      slvActive = 1'b1;
      bitIdx    = -1;
      nacked    = 1'b0;
      slaveSda  = 1'b1;
      startSeen++;
    end
  end

  // STOP: SDA rises while SCL stays high
  always @(posedge sdaLine) begin
    #1;
    if (Reset && SCL && sdaLine && slvActive) begin
      slvActive = 1'b0;
      slaveSda  = 1'b1;
      stopSeen++;
    end
  end

  // Each SCL fall opens a new bit slot; the slave sets up what it drives for it
  always @(negedge SCL) begin
    logic [2:0] bi;
    if (Reset && slvActive) begin
      if (sclFalls > 0 && ($time - lastFall) != SLOT_CLKS * CLK_PER) periodErr++;
      sclFalls++;
      lastFall = $time;
      bitIdx++;
      slaveSda = 1'b1;
      if (bitIdx == 8) begin
        nacked   = forceNack || (rxAddr != EXP_ADDR);
        slaveSda = nacked;
      end else if (!nacked && bitIdx >= 9 && bitIdx <= 16) begin
        bi = 3'(16 - bitIdx);
        slaveSda = slvMsb[bi];
      end else if (!nacked && bitIdx >= 18 && bitIdx <= 25) begin
        bi = 3'(25 - bitIdx);
        slaveSda = slvLsb[bi];
      end
    end
  end

  // Master-driven bits are read on SCL rise
  always @(posedge SCL) begin
    logic [2:0] bi;
    if (Reset && slvActive) begin
      if (bitIdx >= 0 && bitIdx <= 7) begin
        bi = 3'(7 - bitIdx);
        rxAddr[bi] = sdaLine;
      end
      if (bitIdx == 17) mAck  = sdaLine;
      if (bitIdx == 26) mNack = sdaLine;
    end
  end

  always @(negedge Reset) begin
    slvActive = 1'b0;
    slaveSda  = 1'b1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] temp;
    logic        ackErr;
    logic        dv;
    int          lat;
    int          falls;
  } expT;

  expT        sb[$];
  logic [15:0] lastGood = 16'h0000;
  int  cyc = 0, startCyc = 0, rwErr = 0, dvStray = 0;
  bit  prevBusy = 1'b0;

  always @(posedge Clock) cyc++;

  // Monitor: RW window every cycle, full comparison when Busy falls
  always @(negedge Clock) begin
    bit  expRw;
    expT e;
    if (!Reset) begin
      prevBusy = 1'b0;
    end else begin
      if (Busy && !prevBusy) begin
        startCyc  = cyc;
        rwErr     = 0;
        sclFalls  = 0;
        periodErr = 0;
        startSeen = 0;
        stopSeen  = 0;
        rxAddr    = 8'h00;
        mAck      = 1'bx;
        mNack     = 1'bx;
      end
      expRw = slvActive && (bitIdx == 8 ||
              (!nacked && ((bitIdx >= 9 && bitIdx <= 16) || (bitIdx >= 18 && bitIdx <= 25))));
      if (ReadOrWrite !== expRw) rwErr++;
      if (!Busy && prevBusy) begin
        check("txn_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("temp_data", 32'(TempData), 32'(e.temp));
          check("data_valid", 32'(DataValid), 32'(e.dv));
          check("ack_error", 32'(AckError), 32'(e.ackErr));
          check("latency", cyc - startCyc, e.lat);
          check("scl_falls", sclFalls, e.falls);
          check("scl_period_errs", periodErr, 0);
          check("rw_window_errs", rwErr, 0);
          check("addr_byte", 32'(rxAddr), 32'(EXP_ADDR));
          check("start_cond", startSeen, 1);
          check("stop_cond", stopSeen, 1);
          if (e.dv) begin
            check("master_ack", 32'(mAck), 32'd0);
            check("master_nack", 32'(mNack), 32'd1);
          end
        end
      end else if (DataValid) begin
        dvStray++;
      end
      prevBusy = Busy;
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge with the controller idle; leaves Start low at the next negedge
  task automatic issueRead(input logic [7:0] m, input logic [7:0] l, input bit nack);
    expT e;
    slvMsb    = m;
    slvLsb    = l;
    forceNack = nack;
    if (!nack) lastGood = {m, l};
    e.temp   = lastGood;
    e.dv     = !nack;
    e.ackErr = nack;
    e.lat    = (nack ? 11 : 29) * SLOT_CLKS;
    e.falls  = nack ? 10 : 28;
    sb.push_back(e);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    repeat (2) @(negedge Clock);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_scl"},        32'(SCL), 32'd1);
    check({tag, "_rw"},         32'(ReadOrWrite), 32'd0);
    check({tag, "_select"},     32'(Select), 32'd0);
    check({tag, "_ssa"},        32'(StartStopAck), 32'd1);
    check({tag, "_sdo"},        32'(ShiftDataOut), 32'd0);
    check({tag, "_temp"},       32'(TempData), 32'd0);
    check({tag, "_data_valid"}, 32'(DataValid), 32'd0);
    check({tag, "_busy"},       32'(Busy), 32'd0);
    check({tag, "_ack_error"},  32'(AckError), 32'd0);
  endtask

  initial begin
    int n;
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    checkResetOutputs("reset");
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    // Basic read
    issueRead(8'h19, 8'h40, 1'b0);
    waitDrain(1000);

    // Address NACK keeps previous TempData
    issueRead(8'($urandom), 8'($urandom), 1'b1);
    waitDrain(1000);

    // Start spammed while busy: one transaction only
    issueRead(8'($urandom), 8'($urandom), 1'b0);
    n = 0;
    while (Busy && n < 1000) begin
      Start = 1'($urandom_range(0, 1));
      @(negedge Clock);
      n++;
    end
    Start = 1'b0;
    waitDrain(10);
    repeat (20) @(negedge Clock);
    check("spam_single_busy", 32'(Busy), 32'd0);

    // Random mix of good reads and NACKs
    for (int i = 0; i < 5; i++) begin
      issueRead(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
      waitDrain(1000);
    end

    // Asynchronous reset in the middle of the MSB byte
    issueRead(8'($urandom), 8'($urandom), 1'b0);
    n = 0;
    while (bitIdx != 12 && n < 1000) begin
      @(negedge Clock);
      n++;
    end
    check("reach_rd_msb", bitIdx, 12);
    @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    sb.delete();
    lastGood = 16'h0000;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    issueRead(8'($urandom), 8'($urandom), 1'b0);
    waitDrain(1000);

    // Back-to-back: second Start in the cycle right after DataValid
    issueRead(8'($urandom), 8'($urandom), 1'b0);
    n = 0;
    while (!DataValid && n < 1000) begin
      @(negedge Clock);
      n++;
    end
    check("b2b_first_valid", 32'(DataValid), 32'd1);
    @(negedge Clock);
    issueRead(8'hFF, 8'hF0, 1'b0);
    check("b2b_start_scl", 32'(SCL), 32'd1);
    check("b2b_start_sda", 32'(sdaLine), 32'd1);
    check("b2b_start_busy", 32'(Busy), 32'd1);
    waitDrain(1000);
    check("b2b_final_temp", 32'(TempData), 32'h0000FFF0);

    check("stray_data_valid", dvStray, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
